multilane_block_lock_fsm: RTL and testbench
===========================================

Name: multilane_block_lock_fsm

Overview:
Per-lane 66b sync-header block-lock engine for the N-lane 100GbE PCS receive path. It runs one independent lock FSM per lane with Clause-82-style rules: it locks after a programmable count of consecutive valid headers, and it loses lock on a programmable invalid count within a programmable window. Each lane drives the bit-slip index for its block aligner. The block sits between the per-lane sync-header checkers and the lane deskew/reorder stage.

Parameters:
N_LANES, 20, number of independent lanes
NB_CODED_BLOCK, 66, coded block length; index range 0..NB_CODED_BLOCK-1
MAX_WINDOW, 1024, maximum programmable window/lock count
NB_INDEX, $clog2(NB_CODED_BLOCK), search/block index width
NB_CNT, $clog2(MAX_WINDOW+1), width of counters and limit inputs

Ports:
i_clock  in  1  single clock
i_reset  in  1  synchronous active-high reset
i_enable  in  1  global enable
i_valid  in  1  data-valid strobe, common to all lanes
i_signal_ok  in  N_LANES  per-lane PMA signal ok
i_sh_valid  in  N_LANES  per-lane current header valid (sh==01/10)
i_lock_limit  in  NB_CNT  consecutive valid headers needed to lock (nominal 64)
i_window_limit  in  NB_CNT  headers per locked test window (nominal 1024)
i_invalid_limit  in  NB_CNT  invalid headers per window that drop lock (nominal 65)
i_clear_flags  in  1  clears sticky lock-lost flags
o_block_index  out  N_LANES*NB_INDEX  per-lane alignment index; lane k at [k*NB_INDEX +: NB_INDEX]
o_block_lock  out  N_LANES  per-lane lock
o_all_lock  out  1  AND of o_block_lock
o_slip  out  N_LANES  one-cycle pulse on index change
o_lock_lost  out  N_LANES  sticky flag: lane went from LOCKED to UNLOCKED

Behaviour:
- Reset clears all state: every lane goes to UNLOCKED with index 0, all counters 0, all outputs 0.
- Test event for lane k: i_enable && i_valid && i_signal_ok[k]. Without a test event, all lane state holds.
- UNLOCKED state, on a test event:
  - sh invalid: slip. Index increments, wrapping from NB_CODED_BLOCK-1 to 0. sh_cnt is set to 0.
  - sh valid: sh_cnt increments. If sh_cnt+1 >= i_lock_limit, the lane goes to LOCKED and sh_cnt and inv_cnt are set to 0. The index does not change.
- LOCKED state, on a test event:
  - sh_cnt increments. inv_cnt increments when the header is invalid.
  - If the updated inv_cnt >= i_invalid_limit: go to UNLOCKED, slip (index+1 with wrap), set o_lock_lost[k], clear both counters.
  - Else if the updated sh_cnt >= i_window_limit: clear both counters and stay LOCKED.
  - The invalid-limit check takes priority when it coincides with window end.
- A limit of 0 behaves as 1, because all comparisons use >=.
- Counters saturate at all-ones and never wrap.
- i_signal_ok[k] low is a synchronous per-lane clear: UNLOCKED, index 0, counters 0, no o_slip pulse. It sets o_lock_lost[k] if the lane was LOCKED. Other lanes are unaffected.
- Latency:
  - o_block_lock, o_block_index and o_slip are registered and change on the clock edge that consumes the deciding test event.
  - o_slip[k] is high for exactly the one cycle in which the new index is first presented.
  - o_all_lock is combinational from the registered lock bits.
- o_lock_lost:
  - Set when any of the above lock-drop events occurs.
  - Cleared by i_clear_flags.
  - If set and clear happen in the same cycle, set wins.
- Limit inputs are sampled on every test event. Changing them mid-window takes effect on the next comparison.

Test Plan:
Configuration for all scenarios: N_LANES=4, NB_CODED_BLOCK=66, limits 64/1024/65.
1. Lane 0 receives 63 valid headers -> o_block_lock[0]=0. The 64th valid header -> o_block_lock[0]=1 on that edge; index is unchanged; o_slip[0] never pulses.
2. Lane 1 receives continuous invalid headers from reset -> index steps 0,1,…,65,0; o_slip[1] pulses once per test; lock stays 0. A valid run of 64 at index 5 -> lock with index 5.
3. Lane 2 locked, 64 invalid headers in a 1024-header window -> stays locked and counters clear at header 1024. Next window, 65 invalid -> unlock on the 65th; index+1; o_slip[2] pulses; o_lock_lost[2]=1.
4. Lane 0 locked, then i_valid deasserted for 100 cycles during a partial window -> counters and index hold. After resume, the window ends exactly at header 1024 counted across the gap.
5. All lanes locked (o_all_lock=1), then i_signal_ok[3] pulsed low for one cycle -> lane 3 index 0, unlocked, o_lock_lost[3]=1, o_all_lock=0, lanes 0-2 unchanged. i_clear_flags on the same edge as a new lock-lost event -> flag remains 1.
6. i_reset asserted mid-lock on all lanes -> next edge all outputs 0. i_lock_limit=0 -> a single valid header locks the lane.

Source files
------------

// File: rtl/multilane_block_lock_fsm.sv
// Per-lane 66b sync-header block lock: locks after a run of valid headers, drops on too many invalid per window.
// Lock/index/slip are registered on the deciding test event; no backpressure, idle cycles simply hold lane state.
module multilane_block_lock_fsm #(
  parameter int N_LANES        = 20,
  parameter int NB_CODED_BLOCK = 66,
  parameter int MAX_WINDOW     = 1024,
  parameter int NB_INDEX       = $clog2(NB_CODED_BLOCK),
  parameter int NB_CNT         = $clog2(MAX_WINDOW + 1)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic [N_LANES-1:0]           i_signal_ok,
  input  logic [N_LANES-1:0]           i_sh_valid,
  input  logic [NB_CNT-1:0]            i_lock_limit,
  input  logic [NB_CNT-1:0]            i_window_limit,
  input  logic [NB_CNT-1:0]            i_invalid_limit,
  input  logic                         i_clear_flags,
  output logic [N_LANES*NB_INDEX-1:0]  o_block_index,
  output logic [N_LANES-1:0]           o_block_lock,
  output logic                         o_all_lock,
  output logic [N_LANES-1:0]           o_slip,
  output logic [N_LANES-1:0]           o_lock_lost
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    lock_state_e         state;
    logic [NB_INDEX-1:0] idx;
    logic [NB_CNT-1:0]   sh_cnt;
    logic [NB_CNT-1:0]   inv_cnt;
    logic                slip;
    logic                lost;
  } lane_t;

  lane_t              lane_q [N_LANES];
  lane_t              lane_d [N_LANES];
  logic [N_LANES-1:0] test_evt;

  assign test_evt = {N_LANES{i_enable & i_valid}} & i_signal_ok;

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + NB_CNT'(1);
  endfunction

  function automatic logic [NB_INDEX-1:0] idx_inc(input logic [NB_INDEX-1:0] v);
    return (v == NB_INDEX'(NB_CODED_BLOCK - 1)) ? '0 : v + NB_INDEX'(1);
  endfunction

  function automatic lane_t lane_step(input lane_t cur, input logic test,
                                      input logic sig_ok, input logic shv);
    lane_t             nxt;
    logic [NB_CNT-1:0] sh_n;
    logic [NB_CNT-1:0] inv_n;
    nxt      = cur;
    nxt.slip = 1'b0;
    sh_n     = sat_inc(cur.sh_cnt);
    inv_n    = shv ? cur.inv_cnt : sat_inc(cur.inv_cnt);
    // Clear first so a lock-drop in the same cycle re-sets the flag.
    if (i_clear_flags) nxt.lost = 1'b0;
    if (!sig_ok) begin
      if (cur.state == ST_LOCKED) nxt.lost = 1'b1;
      nxt.state   = ST_UNLOCKED;
      nxt.idx     = '0;
      nxt.sh_cnt  = '0;
      nxt.inv_cnt = '0;
    end else if (test) begin
      if (cur.state == ST_UNLOCKED) begin
        if (!shv) begin
          nxt.idx    = idx_inc(cur.idx);
          nxt.slip   = 1'b1;
          nxt.sh_cnt = '0;
        end else if (sh_n >= i_lock_limit) begin
          nxt.state   = ST_LOCKED;
          nxt.sh_cnt  = '0;
          nxt.inv_cnt = '0;
        end else begin
          nxt.sh_cnt = sh_n;
        end
      end else begin
        if (inv_n >= i_invalid_limit) begin
          nxt.state   = ST_UNLOCKED;
          nxt.idx     = idx_inc(cur.idx);
          nxt.slip    = 1'b1;
          nxt.lost    = 1'b1;
          nxt.sh_cnt  = '0;
          nxt.inv_cnt = '0;
        end else if (sh_n >= i_window_limit) begin
          nxt.sh_cnt  = '0;
          nxt.inv_cnt = '0;
        end else begin
          nxt.sh_cnt  = sh_n;
          nxt.inv_cnt = inv_n;
        end
      end
    end
    return nxt;
  endfunction

  always_comb begin
    lane_d = lane_q;
    for (int k = 0; k < N_LANES; k++) begin
      lane_d[k] = lane_step(lane_q[k], test_evt[k], i_signal_ok[k], i_sh_valid[k]);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_LANES; k++) lane_q[k] <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_out
    assign o_block_index[k*NB_INDEX +: NB_INDEX] = lane_q[k].idx;
    assign o_block_lock[k] = (lane_q[k].state == ST_LOCKED);
    assign o_slip[k]       = lane_q[k].slip;
    assign o_lock_lost[k]  = lane_q[k].lost;
  end

  assign o_all_lock = &o_block_lock;

endmodule

// File: tb/tb_multilane_block_lock_fsm.sv
// Bench for multilane_block_lock_fsm: directed lock/slip/window scenarios plus a randomized phase, all against an integer model.
module tb_multilane_block_lock_fsm;
  localparam int NL   = 4;
  localparam int NBLK = 66;
  localparam int NIX  = $clog2(NBLK);
  localparam int NC   = $clog2(1024 + 1);
  localparam int SAT  = (1 << NC) - 1;

  logic            clk = 1'b0;
  logic            rst, en, vld, clr;
  logic [NL-1:0]   sig_ok, shv;
  logic [NC-1:0]   lock_lim, win_lim, inv_lim;
  logic [NL*NIX-1:0] o_index;
  logic [NL-1:0]   o_lock, o_slip, o_lost;
  logic            o_all;

  int n_chk = 0;
  int n_err = 0;

  int m_lock [NL];
  int m_idx  [NL];
  int m_sh   [NL];
  int m_inv  [NL];
  int m_slip [NL];
  int m_lost [NL];

  always #5 clk = ~clk;

  multilane_block_lock_fsm #(.N_LANES(NL), .NB_CODED_BLOCK(NBLK), .MAX_WINDOW(1024)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld),
    .i_signal_ok(sig_ok), .i_sh_valid(shv),
    .i_lock_limit(lock_lim), .i_window_limit(win_lim), .i_invalid_limit(inv_lim),
    .i_clear_flags(clr),
    .o_block_index(o_index), .o_block_lock(o_lock), .o_all_lock(o_all),
    .o_slip(o_slip), .o_lock_lost(o_lost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat1(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic int idx_of(input int k);
    return int'(o_index[k*NIX +: NIX]);
  endfunction

  // Model the rules on integers, using the inputs present at the edge.
  task automatic model_step();
    for (int k = 0; k < NL; k++) begin
      if (rst) begin
        m_lock[k] = 0; m_idx[k] = 0; m_sh[k] = 0; m_inv[k] = 0; m_slip[k] = 0; m_lost[k] = 0;
      end else begin
        m_slip[k] = 0;
        if (clr) m_lost[k] = 0;
        if (!sig_ok[k]) begin
          if (m_lock[k] != 0) m_lost[k] = 1;
          m_lock[k] = 0; m_idx[k] = 0; m_sh[k] = 0; m_inv[k] = 0;
        end else if (en && vld) begin
          if (m_lock[k] == 0) begin
            if (!shv[k]) begin
              m_idx[k] = (m_idx[k] + 1) % NBLK; m_sh[k] = 0; m_slip[k] = 1;
            end else begin
              m_sh[k] = sat1(m_sh[k]);
              if (m_sh[k] >= int'(lock_lim)) begin
                m_lock[k] = 1; m_sh[k] = 0; m_inv[k] = 0;
              end
            end
          end else begin
            m_sh[k] = sat1(m_sh[k]);
            if (!shv[k]) m_inv[k] = sat1(m_inv[k]);
            if (m_inv[k] >= int'(inv_lim)) begin
              m_lock[k] = 0; m_idx[k] = (m_idx[k] + 1) % NBLK; m_slip[k] = 1;
              m_lost[k] = 1; m_sh[k] = 0; m_inv[k] = 0;
            end else if (m_sh[k] >= int'(win_lim)) begin
              m_sh[k] = 0; m_inv[k] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int all_exp;
    all_exp = 1;
    for (int k = 0; k < NL; k++) begin
      chk($sformatf("lock%0d", k), o_lock[k], m_lock[k]);
      chk($sformatf("idx%0d", k),  idx_of(k), m_idx[k]);
      chk($sformatf("slip%0d", k), o_slip[k], m_slip[k]);
      chk($sformatf("lost%0d", k), o_lost[k], m_lost[k]);
      if (m_lock[k] == 0) all_exp = 0;
    end
    chk("all_lock", o_all, all_exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int slips0, slips1;
    rst = 1'b1; en = 1'b0; vld = 1'b0; clr = 1'b0; sig_ok = '0; shv = '0;
    lock_lim = NC'(64); win_lim = NC'(1024); inv_lim = NC'(65);
    run(2);
    rst = 1'b0; en = 1'b1; vld = 1'b1; sig_ok = 4'hF;

    // Lane 0 locks after 64 valid; lane 1 slips through every index.
    shv = 4'b1101; slips0 = 0; slips1 = 0;
    for (int i = 0; i < 63; i++) begin
      cycle(); slips0 += int'(o_slip[0]); slips1 += int'(o_slip[1]);
    end
    chk("s1_lock_at63", o_lock[0], 0);
    cycle(); slips0 += int'(o_slip[0]); slips1 += int'(o_slip[1]);
    chk("s1_lock_at64", o_lock[0], 1);
    chk("s1_idx", idx_of(0), 0);
    for (int i = 0; i < 2; i++) begin
      cycle(); slips0 += int'(o_slip[0]); slips1 += int'(o_slip[1]);
    end
    chk("s1_no_slip", slips0, 0);
    chk("s2_slip_count", slips1, 66);
    chk("s2_wrap_idx", idx_of(1), 0);
    chk("s2_unlocked", o_lock[1], 0);
    run(5);
    shv = 4'hF;
    run(64);
    chk("s2_lock", o_lock[1], 1);
    chk("s2_lock_idx", idx_of(1), 5);

    // Lane 2: fresh window, 64 invalid survive, 65 in the next window drop lock.
    sig_ok = 4'hB; cycle();
    sig_ok = 4'hF; clr = 1'b1; cycle(); clr = 1'b0;
    run(63);
    chk("s3_relock", o_lock[2], 1);
    shv = 4'hB; run(64);
    shv = 4'hF; run(960);
    chk("s3_window_survive", o_lock[2], 1);
    shv = 4'hB; run(64);
    chk("s3_64inv_locked", o_lock[2], 1);
    cycle();
    chk("s3_unlock", o_lock[2], 0);
    chk("s3_idx", idx_of(2), 1);
    chk("s3_slip", o_slip[2], 1);
    chk("s3_lost", o_lost[2], 1);

    // Lane 0: window counted across a 100-cycle valid gap.
    shv = 4'hF;
    sig_ok = 4'hE; cycle(); sig_ok = 4'hF;
    run(64);
    run(500);
    vld = 1'b0; run(100); vld = 1'b1;
    run(523);
    shv = 4'hE; run(65);
    chk("s4_window_end", o_lock[0], 1);
    cycle();
    chk("s4_unlock", o_lock[0], 0);

    // All lanes locked, then lane 3 signal drop and clear/set collision.
    shv = 4'hF; run(64);
    chk("s5_all_lock", o_all, 1);
    sig_ok = 4'h7; cycle();
    chk("s5_idx3", idx_of(3), 0);
    chk("s5_lock3", o_lock[3], 0);
    chk("s5_lost3", o_lost[3], 1);
    chk("s5_all_drop", o_all, 0);
    chk("s5_others", o_lock[2:0], 3'b111);
    sig_ok = 4'hB; clr = 1'b1; cycle();
    chk("s5_set_wins", o_lost[2], 1);
    chk("s5_cleared3", o_lost[3], 0);
    clr = 1'b0; sig_ok = 4'hF;

    // Reset mid-lock, then a zero lock limit.
    run(64);
    rst = 1'b1; cycle();
    chk("s6_rst_lock", o_lock, 0);
    chk("s6_rst_idx", o_index, 0);
    chk("s6_rst_lost", o_lost, 0);
    rst = 1'b0; lock_lim = '0; cycle();
    chk("s6_lim0_lock", o_lock, 4'hF);

    // Randomized phase with small, occasionally changing limits.
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) begin
        lock_lim = NC'($urandom_range(0, 8));
        win_lim  = NC'($urandom_range(0, 40));
        inv_lim  = NC'($urandom_range(0, 6));
      end
      en  = ($urandom_range(0, 19) != 0);
      vld = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 999) == 0);
      for (int k = 0; k < NL; k++) begin
        sig_ok[k] = ($urandom_range(0, 63) != 0);
        shv[k]    = ($urandom_range(0, 9) < 7);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
